// File: rtl/rf_write_scheduler_pkg.sv
// Shared register-file constants for the writeback path: geometry, the
// hard-wired zero register and the requester index assignment.
package rf_pkg;

  localparam int unsigned RF_ADDR_W   = 3;
  localparam int unsigned RF_DATA_W   = 8;
  localparam int unsigned RF_NREGS    = 2 ** RF_ADDR_W;
  localparam int unsigned RF_ZERO_REG = 0;

  localparam int unsigned REQ_ALU = 0;
  localparam int unsigned REQ_MEM = 1;
  localparam int unsigned REQ_EXT = 2;

endpackage

// File: rtl/rf_write_scheduler_if.sv
// Writeback request and destination-reservation handshakes into the scheduler.
interface rf_write_scheduler_if #(
  parameter int unsigned NUM_REQ = 3,
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned ADDR_W  = 3
) ();

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_ready;
  logic                      rsv_valid;
  logic [ADDR_W-1:0]         rsv_addr;
  logic                      rsv_ready;

  modport master (
    output req_valid, req_addr, req_data, rsv_valid, rsv_addr,
    input  req_ready, rsv_ready
  );

  modport slave (
    input  req_valid, req_addr, req_data, rsv_valid, rsv_addr,
    output req_ready, rsv_ready
  );

endinterface

// File: rtl/rf_write_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: first active request at or above ptr,
// wrapping modulo NUM_REQ.
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 3,
  localparam int unsigned PTR_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [PTR_W-1:0]   idx
);

  int unsigned      pos;
  logic [PTR_W-1:0] j;
  logic             found;

  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    pos   = 0;
    j     = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      pos = 32'(ptr) + k;
      if (pos >= NUM_REQ) pos = pos - NUM_REQ;
      j = PTR_W'(pos);
      if (!found && req[j]) begin
        found    = 1'b1;
        grant[j] = 1'b1;
        idx      = j;
      end
    end
  end

endmodule

// File: rtl/rf_write_scheduler.sv
// Shares the register file write port among writeback requesters and keeps
// the busy scoreboard of reserved destinations for hazard detection.
module rf_write_scheduler
  import rf_pkg::*;
#(
  parameter int unsigned NUM_REQ = 3,
  parameter int unsigned DATA_W  = RF_DATA_W,
  parameter int unsigned ADDR_W  = RF_ADDR_W
) (
  input  logic                   clk,
  input  logic                   rst,
  rf_write_scheduler_if.slave    bus,
  output logic [2**ADDR_W-1:0]   busy,
  output logic [ADDR_W-1:0]      rf_d_address,
  output logic [DATA_W-1:0]      rf_datain,
  output logic                   rf_write_en
);

  localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PTR_W-1:0]    rr_ptr;
  logic [PTR_W-1:0]    gnt_idx;
  logic [NUM_REQ-1:0]  gnt;
  logic [ADDR_W-1:0]   g_addr;
  logic [DATA_W-1:0]   g_data;
  logic                wr_hs;
  logic                rsv_hs;
  logic [2**ADDR_W-1:0] busy_nxt;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req   (bus.req_valid),
    .ptr   (rr_ptr),
    .grant (gnt),
    .idx   (gnt_idx)
  );

  assign bus.req_ready = rst ? '0 : gnt;
  assign wr_hs         = !rst && (|gnt);
  assign bus.rsv_ready = !rst && !busy[bus.rsv_addr];
  assign rsv_hs        = bus.rsv_valid && bus.rsv_ready;

  always_comb begin
    g_addr = '0;
    g_data = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        g_addr = bus.req_addr[i*ADDR_W +: ADDR_W];
        g_data = bus.req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  // Set is applied after clear: rsv_ready already blocks a busy target, so a
  // same-cycle set can only win when the register was free.
  always_comb begin
    busy_nxt = busy;
    if (wr_hs)  busy_nxt[g_addr]       = 1'b0;
    if (rsv_hs) busy_nxt[bus.rsv_addr] = 1'b1;
    busy_nxt[RF_ZERO_REG] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy         <= '0;
      rf_write_en  <= 1'b0;
      rf_d_address <= '0;
      rf_datain    <= '0;
      rr_ptr       <= '0;
    end else begin
      busy        <= busy_nxt;
      rf_write_en <= wr_hs && (g_addr != ADDR_W'(RF_ZERO_REG));
      if (wr_hs) begin
        rf_d_address <= g_addr;
        rf_datain    <= g_data;
        rr_ptr       <= (gnt_idx == PTR_W'(NUM_REQ - 1)) ? '0 : gnt_idx + PTR_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_rf_write_scheduler.sv
// Directed bench: expected register-file writes go into a scoreboard queue
// consumed by a negedge monitor; handshake and scoreboard outputs are checked inline.
module tb_rf_write_scheduler;
  import rf_pkg::*;

  localparam int unsigned NR = 3;
  localparam int unsigned DW = 8;
  localparam int unsigned AW = 3;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wr_t;

  logic          clk = 1'b0;
  logic          rst;
  logic [7:0]    busy;
  logic [AW-1:0] rf_d_address;
  logic [DW-1:0] rf_datain;
  logic          rf_write_en;

  int unsigned checks = 0;
  int unsigned errors = 0;
  wr_t         exp_q[$];
  logic [DW-1:0] rf_mem [8];

  rf_write_scheduler_if #(.NUM_REQ(NR), .DATA_W(DW), .ADDR_W(AW)) bus ();

  rf_write_scheduler #(.NUM_REQ(NR), .DATA_W(DW), .ADDR_W(AW)) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .busy         (busy),
    .rf_d_address (rf_d_address),
    .rf_datain    (rf_datain),
    .rf_write_en  (rf_write_en)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Register file model plus scoreboard: every write pulse must match the queue head.
  always @(negedge clk) begin
    if (rf_write_en === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write", {21'd0, rf_d_address, rf_datain}, 32'hFFFF_FFFF);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check("write_addr", 32'(rf_d_address), 32'(e.a));
        check("write_data", 32'(rf_datain), 32'(e.d));
      end
      rf_mem[rf_d_address] = rf_datain;
    end
  end

  task automatic to_pos();
    @(posedge clk); #1;
  endtask

  task automatic to_neg();
    @(negedge clk); #1;
  endtask

  task automatic set_req(input int unsigned i, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.req_addr[i*AW +: AW] = a;
    bus.req_data[i*DW +: DW] = d;
  endtask

  task automatic expect_wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    wr_t e;
    e.a = a;
    e.d = d;
    exp_q.push_back(e);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  logic [2:0] rr_gnt  [4] = '{3'b001, 3'b010, 3'b100, 3'b001};
  logic [2:0] rr_addr [4] = '{3'd1, 3'd2, 3'd3, 3'd1};
  logic [7:0] rr_data [4] = '{8'h11, 8'h22, 8'h33, 8'h11};

  initial begin
    for (int i = 0; i < 8; i++) rf_mem[i] = '0;
    rst = 1'b1;
    bus.req_valid = '0;
    bus.req_addr  = '0;
    bus.req_data  = '0;
    bus.rsv_valid = 1'b0;
    bus.rsv_addr  = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_busy", 32'(busy), 32'h0);
    check("reset_wen", 32'(rf_write_en), 32'h0);
    check("reset_addr", 32'(rf_d_address), 32'h0);
    check("reset_data", 32'(rf_datain), 32'h0);
    to_neg();
    rst = 1'b0;

    // Reserve r2 and r3 to build busy=0x0C before the mid-operation reset.
    bus.rsv_valid = 1'b1;
    bus.rsv_addr  = 3'd2;
    #1 check("rsv_r2_ready", 32'(bus.rsv_ready), 32'h1);
    to_pos(); to_neg();
    bus.rsv_addr  = 3'd3;
    #1 check("rsv_r3_ready", 32'(bus.rsv_ready), 32'h1);
    to_pos();
    check("busy_0c", 32'(busy), 32'h0C);
    to_neg();
    bus.rsv_valid = 1'b0;

    // Reset while all requesters are valid.
    set_req(REQ_ALU, 3'd1, 8'h11);
    set_req(REQ_MEM, 3'd2, 8'h22);
    set_req(REQ_EXT, 3'd3, 8'h33);
    bus.req_valid = 3'b111;
    rst = 1'b1;
    #1;
    check("rst_req_ready", 32'(bus.req_ready), 32'h0);
    check("rst_rsv_ready", 32'(bus.rsv_ready), 32'h0);
    to_pos();
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_wen", 32'(rf_write_en), 32'h0);
    to_neg();
    rst = 1'b0;

    // Round robin with all three valid.
    for (int k = 0; k < 4; k++) begin
      #1 check("rr_grant", 32'(bus.req_ready), 32'(rr_gnt[k]));
      expect_wr(rr_addr[k], rr_data[k]);
      to_pos();
      check("rr_wen", 32'(rf_write_en), 32'h1);
      to_neg();
      check("rr_readback", 32'(rf_mem[rr_addr[k]]), 32'(rr_data[k]));
    end
    bus.req_valid = '0;

    // Register 0: write consumed without a pulse; reservation of r0 never sets busy.
    set_req(REQ_MEM, 3'd0, 8'hFF);
    bus.req_valid = 3'b010;
    bus.rsv_valid = 1'b1;
    bus.rsv_addr  = 3'd0;
    #1;
    check("r0_req_ready", 32'(bus.req_ready), 32'h2);
    check("r0_rsv_ready", 32'(bus.rsv_ready), 32'h1);
    to_pos();
    check("r0_wen", 32'(rf_write_en), 32'h0);
    check("r0_busy", 32'(busy), 32'h0);
    to_neg();
    check("r0_file", 32'(rf_mem[0]), 32'h0);
    bus.req_valid = '0;

    // Scoreboard on r5.
    bus.rsv_addr = 3'd5;
    #1 check("r5_rsv_ready", 32'(bus.rsv_ready), 32'h1);
    to_pos();
    check("r5_busy", 32'(busy), 32'h20);
    to_neg();
    #1 check("r5_rerserve_ready", 32'(bus.rsv_ready), 32'h0);
    to_pos();
    check("r5_busy_hold", 32'(busy), 32'h20);
    to_neg();
    bus.rsv_valid = 1'b0;
    set_req(REQ_ALU, 3'd5, 8'hA5);
    bus.req_valid = 3'b001;
    #1 check("r5_wr_grant", 32'(bus.req_ready), 32'h1);
    expect_wr(3'd5, 8'hA5);
    to_pos();
    check("r5_busy_clear", 32'(busy), 32'h0);
    to_neg();
    check("r5_file", 32'(rf_mem[5]), 32'hA5);
    bus.req_valid = '0;
    bus.rsv_valid = 1'b1;
    #1 check("r5_rsv_again", 32'(bus.rsv_ready), 32'h1);
    to_pos();
    check("r5_busy_again", 32'(busy), 32'h20);
    to_neg();

    // Collision on busy r4: clear only, reservation retries next cycle.
    bus.rsv_addr = 3'd4;
    to_pos();
    check("r4_busy", 32'(busy), 32'h30);
    to_neg();
    set_req(REQ_MEM, 3'd4, 8'h44);
    bus.req_valid = 3'b010;
    #1;
    check("r4_coll_rsv_ready", 32'(bus.rsv_ready), 32'h0);
    check("r4_coll_grant", 32'(bus.req_ready), 32'h2);
    expect_wr(3'd4, 8'h44);
    to_pos();
    check("r4_coll_busy", 32'(busy), 32'h20);
    to_neg();
    bus.req_valid = '0;
    #1 check("r4_retry_ready", 32'(bus.rsv_ready), 32'h1);
    to_pos();
    check("r4_retry_busy", 32'(busy), 32'h30);
    to_neg();

    // Collision on free r6: set wins.
    bus.rsv_addr = 3'd6;
    set_req(REQ_EXT, 3'd6, 8'h66);
    bus.req_valid = 3'b100;
    #1;
    check("r6_coll_rsv_ready", 32'(bus.rsv_ready), 32'h1);
    check("r6_coll_grant", 32'(bus.req_ready), 32'h4);
    expect_wr(3'd6, 8'h66);
    to_pos();
    check("r6_coll_busy", 32'(busy), 32'h70);
    to_neg();
    bus.req_valid = '0;
    bus.rsv_valid = 1'b0;

    // Idle hold for 5 cycles.
    for (int k = 0; k < 5; k++) begin
      #1 check("idle_ready", 32'(bus.req_ready), 32'h0);
      to_pos();
      check("idle_wen", 32'(rf_write_en), 32'h0);
      check("idle_addr", 32'(rf_d_address), 32'h6);
      check("idle_data", 32'(rf_datain), 32'h66);
      to_neg();
    end

    // Pointer sat at 0 through idle: req 1 beats req 2, then req 2 alone goes next.
    set_req(REQ_MEM, 3'd3, 8'h5A);
    set_req(REQ_EXT, 3'd7, 8'h77);
    bus.req_valid = 3'b110;
    #1 check("post_idle_grant", 32'(bus.req_ready), 32'h2);
    expect_wr(3'd3, 8'h5A);
    to_pos(); to_neg();
    bus.req_valid = 3'b100;
    #1 check("req2_single_grant", 32'(bus.req_ready), 32'h4);
    expect_wr(3'd7, 8'h77);
    to_pos();
    check("req2_wen", 32'(rf_write_en), 32'h1);
    to_neg();
    check("req2_file", 32'(rf_mem[7]), 32'h77);
    bus.req_valid = '0;

    repeat (3) to_neg();
    check("queue_drained", 32'(exp_q.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
